systolic_mesh_os: RTL and testbench
===================================

SYSTOLIC_MESH_OS -- requirements
Module: systolic_mesh_os

Interface
REQ-001 SHALL have parameter ROWS, default 4, mesh row count (>=1).
REQ-002 SHALL have parameter COLS, default 4, mesh column count (>=1).
REQ-003 SHALL have parameter DATA_WIDTH, default 16, signed operand width.
REQ-004 SHALL have parameter ACC_WIDTH, default 40, signed accumulator width (>=2*DATA_WIDTH).
REQ-005 SHALL have parameter KW, default 16, width of the depth field.
REQ-006 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rstn_i, input, 1, reset: synchronous, active-low.
REQ-008 SHALL have port start_i, input, 1, begin a tile; honoured only in IDLE.
REQ-009 SHALL have port k_len_i, input, KW, tile depth; sampled with start_i.
REQ-010 SHALL have port in_valid_i, input, 1, operand beat valid.
REQ-011 SHALL have port in_ready_o, output, 1, operand beat accepted.
REQ-012 SHALL have port west_i, input, ROWS x DATA_WIDTH, A column k, unskewed.
REQ-013 SHALL have port north_i, input, COLS x DATA_WIDTH, B row k, unskewed.
REQ-014 SHALL have port res_valid_o, input/output pair with res_ready_i (input, 1); res_valid_o output, 1, result row valid.
REQ-015 SHALL have port res_data_o, output, COLS x ACC_WIDTH, one result row.
REQ-016 SHALL have port res_row_o, output, $clog2(ROWS) (min 1), index of the row on res_data_o.
REQ-017 SHALL have ports busy_o (output, 1, state != IDLE) and done_o (output, 1, one-cycle tile-complete pulse).

Function
REQ-018 SHALL implement states IDLE, LOAD, FLUSH, DRAIN, DONE.
REQ-019 IDLE + start_i: latch k_len_i, clear all accumulators and skew registers, go to LOAD next cycle; k_len_i==0 goes directly to DRAIN with all-zero results.
REQ-020 in_ready_o SHALL be 1 exactly in LOAD; a beat transfers when in_valid_i && in_ready_o; gaps (in_valid_i low) are legal and insert bubbles.
REQ-021 Internal skew: west lane r delayed r cycles, north lane c delayed c cycles, each carrying its valid bit; PE(r,c) receives operands and valid r+c cycles after acceptance and forwards them east/south with one register stage.
REQ-022 PE(r,c) SHALL accumulate only on a valid cycle: acc += sign-extended signed product of the west and north operands.
REQ-023 Accumulation SHALL wrap modulo 2^ACC_WIDTH (unless REQ-032).
REQ-024 After the k_len-th beat is accepted: LOAD -> FLUSH; FLUSH lasts exactly ROWS+COLS-1 cycles, then DRAIN.
REQ-025 DRAIN: present rows 0..ROWS-1 in ascending order, one row per handshake (res_valid_o && res_ready_i); res_valid_o is 1 on the first DRAIN cycle; data and index SHALL be held stable while res_ready_i is 0.
REQ-026 Handshake on row ROWS-1 -> DONE; DONE asserts done_o for one cycle, then IDLE.
REQ-027 start_i outside IDLE SHALL be ignored; it has no effect on state or results.
REQ-028 Back-to-back: start_i in the IDLE cycle following DONE SHALL be accepted.

Reset
REQ-029 rstn_i low at a clock edge SHALL, from any state including mid-LOAD/DRAIN, force IDLE and zero all accumulators, skew/pipeline registers, counters and the latched depth.
REQ-030 Output values during reset SHALL be: in_ready_o=0, res_valid_o=0, res_data_o=0, res_row_o=0, busy_o=0, done_o=0.

Configuration
REQ-031 Macro MESH_SATURATE_EN SHALL select accumulator overflow mode.
REQ-032 With MESH_SATURATE_EN defined, accumulation SHALL clamp to the max/min signed ACC_WIDTH value. Without it, accumulation SHALL wrap per REQ-023.

Structure
REQ-033 Package mesh_pkg SHALL hold the state enum (mesh_state_t) and the width helper constants.
REQ-034 One sub-module, mesh_os_pe (register-forwarding MAC cell), SHALL be instantiated ROWS x COLS times.

Verification
REQ-035 2x2, DATA_WIDTH 16, k_len=2, beats west=[1,3]/north=[5,6] then west=[2,4]/north=[7,8], res_ready_i=1 -> row0=[19,22], row1=[43,50], done_o once.
REQ-036 Same tile with in_valid_i low one cycle between beats and res_ready_i low for 3 cycles on row0 -> identical results, row0 held stable, FLUSH still ROWS+COLS-1 cycles.
REQ-037 k_len=0 -> no in_ready_o, two zero rows drained, done_o pulse.
REQ-038 DATA_WIDTH 8, ACC_WIDTH 16, k_len=4, all operands 127 -> wrap: 64516 mod 2^16 = -1020; saturate build: 32767.
REQ-039 rstn_i low mid-DRAIN after row0 -> IDLE next cycle with all outputs zero; a new tile then yields correct results.
REQ-040 3x5 mesh, k_len=3, start_i pulsed during LOAD -> ignored; results match the golden 3x5 product; a back-to-back start in the following IDLE cycle is accepted.

Source files
------------

// File: rtl/mesh_pkg.sv
// Shared types and width helpers for the output-stationary systolic mesh.
package mesh_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    DRAIN,
    DONE
  } mesh_state_t;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mesh_os_pe.sv
// Output-stationary MAC cell: registers operands east/south and accumulates on valid beats.
// MESH_SATURATE_EN selects clamping instead of two's-complement wrap on the accumulator.
module mesh_os_pe #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic                  a_vld_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  b_vld_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic                  a_vld_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic                  b_vld_o,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prodExt;
  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [DATA_WIDTH-1:0]          a_q, b_q;
  logic                           aVld_q, bVld_q;

  assign prod    = $signed(a_i) * $signed(b_i);
  assign prodExt = ACC_WIDTH'(prod);

`ifdef MESH_SATURATE_EN
  // One guard bit exposes signed overflow of the running sum.
  logic [ACC_WIDTH:0] sumWide;
  assign sumWide = {acc_q[ACC_WIDTH-1], acc_q} + {prodExt[ACC_WIDTH-1], prodExt};
`endif

  always_comb begin
    acc_d = acc_q;
    if (a_vld_i && b_vld_i) begin
`ifdef MESH_SATURATE_EN
      if (sumWide[ACC_WIDTH] != sumWide[ACC_WIDTH-1]) begin
        acc_d = sumWide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        acc_d = sumWide[ACC_WIDTH-1:0];
      end
`else
      acc_d = acc_q + prodExt;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i || clr_i) begin
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      aVld_q <= 1'b0;
      bVld_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      a_q    <= a_i;
      b_q    <= b_i;
      aVld_q <= a_vld_i;
      bVld_q <= b_vld_i;
    end
  end

  assign a_o     = a_q;
  assign a_vld_o = aVld_q;
  assign b_o     = b_q;
  assign b_vld_o = bVld_q;
  assign acc_o   = acc_q;

endmodule

// File: rtl/systolic_mesh_os.sv
// ROWS x COLS output-stationary systolic mesh with input skew, flush timing and row-wise drain.
// MESH_SATURATE_EN (passed through to every PE) selects saturating accumulation.
module systolic_mesh_os
  import mesh_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int KW         = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          start_i,
  input  logic [KW-1:0]                 k_len_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [ROWS*DATA_WIDTH-1:0]    west_i,
  input  logic [COLS*DATA_WIDTH-1:0]    north_i,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [COLS*ACC_WIDTH-1:0]     res_data_o,
  output logic [idx_w(ROWS)-1:0]        res_row_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int RW = idx_w(ROWS);
  localparam int FW = idx_w(ROWS + COLS);

  mesh_state_t     state_q, state_d;
  logic [KW-1:0]   kLen_q, kLen_d;
  logic [KW-1:0]   beatCnt_q, beatCnt_d;
  logic [FW-1:0]   flushCnt_q, flushCnt_d;
  logic [RW-1:0]   rowCnt_q, rowCnt_d;
  logic            beat;
  logic            clr;

  logic [DATA_WIDTH-1:0] aBus [ROWS][COLS+1];
  logic                  aVld [ROWS][COLS+1];
  logic [DATA_WIDTH-1:0] bBus [ROWS+1][COLS];
  logic                  bVld [ROWS+1][COLS];
  logic [ACC_WIDTH-1:0]  accArr [ROWS][COLS];

  assign in_ready_o  = (state_q == LOAD);
  assign beat        = in_valid_i && in_ready_o;
  assign clr         = (state_q == IDLE) && start_i;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign res_valid_o = (state_q == DRAIN);
  assign res_row_o   = (state_q == DRAIN) ? rowCnt_q : '0;

  // Lane r of the west edge is delayed r cycles so wavefronts meet diagonally.
  for (genvar r = 0; r < ROWS; r++) begin : g_west
    if (r == 0) begin : g_direct
      assign aBus[0][0] = west_i[DATA_WIDTH-1:0];
      assign aVld[0][0] = beat;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] sh_q [r];
      logic                  shv_q [r];
      always_ff @(posedge clk_i) begin
        if (!rstn_i || clr) begin
          for (int i = 0; i < r; i++) begin
            sh_q[i]  <= '0;
            shv_q[i] <= 1'b0;
          end
        end else begin
          sh_q[0]  <= west_i[r*DATA_WIDTH +: DATA_WIDTH];
          shv_q[0] <= beat;
          for (int i = 1; i < r; i++) begin
            sh_q[i]  <= sh_q[i-1];
            shv_q[i] <= shv_q[i-1];
          end
        end
      end
      assign aBus[r][0] = sh_q[r-1];
      assign aVld[r][0] = shv_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_north
    if (c == 0) begin : g_direct
      assign bBus[0][0] = north_i[DATA_WIDTH-1:0];
      assign bVld[0][0] = beat;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] sh_q [c];
      logic                  shv_q [c];
      always_ff @(posedge clk_i) begin
        if (!rstn_i || clr) begin
          for (int i = 0; i < c; i++) begin
            sh_q[i]  <= '0;
            shv_q[i] <= 1'b0;
          end
        end else begin
          sh_q[0]  <= north_i[c*DATA_WIDTH +: DATA_WIDTH];
          shv_q[0] <= beat;
          for (int i = 1; i < c; i++) begin
            sh_q[i]  <= sh_q[i-1];
            shv_q[i] <= shv_q[i-1];
          end
        end
      end
      assign bBus[0][c] = sh_q[c-1];
      assign bVld[0][c] = shv_q[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      mesh_os_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .clr_i   (clr),
        .a_i     (aBus[r][c]),
        .a_vld_i (aVld[r][c]),
        .b_i     (bBus[r][c]),
        .b_vld_i (bVld[r][c]),
        .a_o     (aBus[r][c+1]),
        .a_vld_o (aVld[r][c+1]),
        .b_o     (bBus[r+1][c]),
        .b_vld_o (bVld[r+1][c]),
        .acc_o   (accArr[r][c])
      );
    end
  end

  // Operands leaving the east and south edges have no consumer.
  for (genvar r = 0; r < ROWS; r++) begin : g_east
    logic unused_east;
    assign unused_east = ^{aBus[r][COLS], aVld[r][COLS]};
  end
  for (genvar c = 0; c < COLS; c++) begin : g_south
    logic unused_south;
    assign unused_south = ^{bBus[ROWS][c], bVld[ROWS][c]};
  end

  always_comb begin
    res_data_o = '0;
    if (state_q == DRAIN) begin
      for (int c = 0; c < COLS; c++) begin
        res_data_o[c*ACC_WIDTH +: ACC_WIDTH] = accArr[rowCnt_q][c];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    kLen_d     = kLen_q;
    beatCnt_d  = beatCnt_q;
    flushCnt_d = flushCnt_q;
    rowCnt_d   = rowCnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          kLen_d     = k_len_i;
          beatCnt_d  = '0;
          flushCnt_d = '0;
          rowCnt_d   = '0;
          state_d    = (k_len_i == '0) ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        if (beat) begin
          beatCnt_d = beatCnt_q + KW'(1);
          if (beatCnt_q + KW'(1) == kLen_q) begin
            flushCnt_d = '0;
            state_d    = FLUSH;
          end
        end
      end
      // The last beat needs ROWS+COLS-2 hops to reach the far corner PE.
      FLUSH: begin
        if (flushCnt_q == FW'(ROWS + COLS - 2)) begin
          rowCnt_d = '0;
          state_d  = DRAIN;
        end else begin
          flushCnt_d = flushCnt_q + FW'(1);
        end
      end
      DRAIN: begin
        if (res_ready_i) begin
          if (rowCnt_q == RW'(ROWS - 1)) begin
            state_d = DONE;
          end else begin
            rowCnt_d = rowCnt_q + RW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      kLen_q     <= '0;
      beatCnt_q  <= '0;
      flushCnt_q <= '0;
      rowCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      kLen_q     <= kLen_d;
      beatCnt_q  <= beatCnt_d;
      flushCnt_q <= flushCnt_d;
      rowCnt_q   <= rowCnt_d;
    end
  end

endmodule

// File: tb/tb_systolic_mesh_os.sv
// Bench for systolic_mesh_os: a 2x2 (16/40) and a 3x5 (8/16) instance checked against a matrix-product model.
module tb_systolic_mesh_os;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        inValid = 1'b0;
  logic        resReady = 1'b0;
  logic [15:0] kLen = '0;
  int          sel = 0;

  int     wOp [3];
  int     nOp [5];
  int     bw [8][3];
  int     bn [8][5];
  longint expR [3][5];
  longint capR [3][5];
  int     expRow = 0;
  int     curRows = 2, curCols = 2, accW = 40;
  int     doneCnt = 0;
  int     total = 0, bad = 0;
  bit     satMode;

  logic        startA, startB;
  logic [31:0] westA, northA;
  logic [23:0] westB;
  logic [39:0] northB;
  logic [79:0] resDataA, resDataB;
  logic [0:0]  resRowA;
  logic [1:0]  resRowB;
  logic        inReadyA, resValidA, busyA, doneA;
  logic        inReadyB, resValidB, busyB, doneB;

  logic   inReadyS, resValidS, busyS, doneS;
  int     resRowS;
  longint resDat [5];

  always #5 clk = ~clk;

  assign startA = start && (sel == 0);
  assign startB = start && (sel == 1);

  always_comb begin
    for (int r = 0; r < 2; r++) westA[r*16 +: 16] = wOp[r][15:0];
    for (int c = 0; c < 2; c++) northA[c*16 +: 16] = nOp[c][15:0];
    for (int r = 0; r < 3; r++) westB[r*8 +: 8] = wOp[r][7:0];
    for (int c = 0; c < 5; c++) northB[c*8 +: 8] = nOp[c][7:0];
  end

  systolic_mesh_os #(
    .ROWS(2), .COLS(2), .DATA_WIDTH(16), .ACC_WIDTH(40), .KW(16)
  ) u_dutA (
    .clk_i(clk), .rstn_i(rstn), .start_i(startA), .k_len_i(kLen),
    .in_valid_i(inValid), .in_ready_o(inReadyA), .west_i(westA), .north_i(northA),
    .res_valid_o(resValidA), .res_ready_i(resReady), .res_data_o(resDataA),
    .res_row_o(resRowA), .busy_o(busyA), .done_o(doneA)
  );

  systolic_mesh_os #(
    .ROWS(3), .COLS(5), .DATA_WIDTH(8), .ACC_WIDTH(16), .KW(16)
  ) u_dutB (
    .clk_i(clk), .rstn_i(rstn), .start_i(startB), .k_len_i(kLen),
    .in_valid_i(inValid), .in_ready_o(inReadyB), .west_i(westB), .north_i(northB),
    .res_valid_o(resValidB), .res_ready_i(resReady), .res_data_o(resDataB),
    .res_row_o(resRowB), .busy_o(busyB), .done_o(doneB)
  );

  always_comb begin
    if (sel == 0) begin
      inReadyS  = inReadyA;
      resValidS = resValidA;
      busyS     = busyA;
      doneS     = doneA;
      resRowS   = int'(resRowA);
      for (int c = 0; c < 5; c++)
        resDat[c] = (c < 2) ? longint'($signed(resDataA[c*40 +: 40])) : 64'sd0;
    end else begin
      inReadyS  = inReadyB;
      resValidS = resValidB;
      busyS     = busyB;
      doneS     = doneB;
      resRowS   = int'(resRowB);
      for (int c = 0; c < 5; c++)
        resDat[c] = longint'($signed(resDataB[c*16 +: 16]));
    end
  end

  task automatic checkOutput(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic longint fit(input longint v, input int aw, input bit sat);
    longint hi, lo, m, x;
    hi = (longint'(1) <<< (aw - 1)) - 1;
    lo = -(longint'(1) <<< (aw - 1));
    m  = longint'(1) <<< aw;
    if (sat) return (v > hi) ? hi : ((v < lo) ? lo : v);
    x = v & (m - 1);
    if (x > hi) x = x - m;
    return x;
  endfunction

  // Reference: C = A*B taken beat by beat, narrowed to the accumulator width after every step.
  task automatic computeModel(input int k);
    longint acc;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++) begin
        acc = 0;
        if (r < curRows && c < curCols)
          for (int b = 0; b < k; b++)
            acc = fit(acc + longint'(bw[b][r]) * longint'(bn[b][c]), accW, satMode);
        expR[r][c] = acc;
      end
  endtask

  task automatic selectDut(input int s);
    sel     = s;
    curRows = (s == 0) ? 2 : 3;
    curCols = (s == 0) ? 2 : 5;
    accW    = (s == 0) ? 40 : 16;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rstn && doneS) doneCnt++;
    if (rstn && resValidS) begin
      if (expRow >= curRows) begin
        checkOutput("extraRow", expRow, curRows - 1);
      end else begin
        checkOutput("rowIdx", resRowS, expRow);
        for (int c = 0; c < curCols; c++) begin
          checkOutput("rowData", resDat[c], expR[expRow][c]);
          capR[expRow][c] = resDat[c];
        end
        if (resReady) expRow++;
      end
    end
  end

  task automatic checkResetOutputs;
    checkOutput("rstInReady", inReadyS, 0);
    checkOutput("rstResValid", resValidS, 0);
    checkOutput("rstResData", resDat[0], 0);
    checkOutput("rstResRow", resRowS, 0);
    checkOutput("rstBusy", busyS, 0);
    checkOutput("rstDone", doneS, 0);
  endtask

  task automatic applyStimulus(input int k, input bit gap, input int stall,
                               input bit poke, input bit abortRow0);
    int guard, cnt, stallLeft, doneBefore;
    computeModel(k);
    expRow = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++) capR[r][c] = -999;
    doneBefore = doneCnt;
    resReady   = (stall == 0);
    stallLeft  = stall;
    kLen  = 16'(k);
    start = 1'b1;
    tick;
    start = 1'b0;
    checkOutput("startBusy", busyS, 1);
    if (k == 0) begin
      checkOutput("zeroDepthReady", inReadyS, 0);
      checkOutput("zeroDepthValid", resValidS, 1);
    end else begin
      checkOutput("loadReady", inReadyS, 1);
      for (int b = 0; b < k; b++) begin
        for (int r = 0; r < 3; r++) wOp[r] = bw[b][r];
        for (int c = 0; c < 5; c++) nOp[c] = bn[b][c];
        inValid = 1'b1;
        if (poke && b == 1) begin
          start = 1'b1;
          kLen  = 16'd7;
        end
        guard = 0;
        @(negedge clk);
        while (!inReadyS && guard < 50) begin
          @(negedge clk);
          guard++;
        end
        if (guard >= 50) checkOutput("beatTimeout", 0, 1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        start   = 1'b0;
        if (gap && b < k - 1) tick;
      end
      cnt = 0;
      @(negedge clk);
      while (!resValidS && cnt < 100) begin
        cnt++;
        @(negedge clk);
      end
      checkOutput("flushLen", cnt, curRows + curCols - 1);
    end
    guard = 0;
    while (guard < 200) begin
      tick;
      guard++;
      if (stallLeft > 0) begin
        stallLeft--;
        if (stallLeft == 0) resReady = 1'b1;
      end
      if (abortRow0 && expRow >= 1) begin
        rstn     = 1'b0;
        resReady = 1'b0;
        tick;
        checkResetOutputs();
        rstn = 1'b1;
        return;
      end
      if (doneS) break;
    end
    if (guard >= 200) checkOutput("drainTimeout", 0, 1);
    tick;
    checkOutput("donePulse", doneCnt - doneBefore, 1);
    checkOutput("rowsDrained", expRow, curRows);
    checkOutput("idleBusy", busyS, 0);
  endtask

  task automatic loadBasicBeats;
    bw[0][0] = 1; bw[0][1] = 3; bn[0][0] = 5; bn[0][1] = 6;
    bw[1][0] = 2; bw[1][1] = 4; bn[1][0] = 7; bn[1][1] = 8;
  endtask

  initial begin
`ifdef MESH_SATURATE_EN
    satMode = 1'b1;
`else
    satMode = 1'b0;
`endif
    for (int b = 0; b < 8; b++) begin
      for (int r = 0; r < 3; r++) bw[b][r] = 0;
      for (int c = 0; c < 5; c++) bn[b][c] = 0;
    end
    for (int r = 0; r < 3; r++) wOp[r] = 0;
    for (int c = 0; c < 5; c++) nOp[c] = 0;

    selectDut(0);
    tick;
    tick;
    checkResetOutputs();
    selectDut(1);
    checkResetOutputs();
    rstn = 1'b1;
    selectDut(0);
    tick;

    loadBasicBeats();
    applyStimulus(2, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("lit r0c0", capR[0][0], 19);
    checkOutput("lit r0c1", capR[0][1], 22);
    checkOutput("lit r1c0", capR[1][0], 43);
    checkOutput("lit r1c1", capR[1][1], 50);

    applyStimulus(2, 1'b1, 3, 1'b0, 1'b0);
    checkOutput("litGap r0c0", capR[0][0], 19);
    checkOutput("litGap r1c1", capR[1][1], 50);

    applyStimulus(0, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("litZero r0c0", capR[0][0], 0);
    checkOutput("litZero r1c1", capR[1][1], 0);

    bw[0][0] = -3;     bw[0][1] = 100; bn[0][0] = 7;      bn[0][1] = -2;
    bw[1][0] = -32768; bw[1][1] = 5;   bn[1][0] = -32768; bn[1][1] = 9;
    applyStimulus(2, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("litNeg r0c0", capR[0][0], 64'sd1073741803);

    loadBasicBeats();
    applyStimulus(2, 1'b0, 0, 1'b0, 1'b1);
    tick;
    applyStimulus(2, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("litAfterRst r1c0", capR[1][0], 43);

    selectDut(1);
    tick;
    for (int b = 0; b < 3; b++) begin
      for (int r = 0; r < 3; r++) bw[b][r] = (b + 1) * (r + 1) - 4;
      for (int c = 0; c < 5; c++) bn[b][c] = (c - 2) * (b + 2);
    end
    applyStimulus(3, 1'b0, 0, 1'b1, 1'b0);
    checkOutput("lit35 r0c0", capR[0][0], 32);
    checkOutput("lit35 r2c4", capR[2][4], 48);
    applyStimulus(1, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("litB2B r0c0", capR[0][0], 12);

    for (int b = 0; b < 4; b++) begin
      for (int r = 0; r < 3; r++) bw[b][r] = 127;
      for (int c = 0; c < 5; c++) bn[b][c] = 127;
    end
    applyStimulus(4, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("litOvf r0c0", capR[0][0], satMode ? 32767 : -1020);
    checkOutput("litOvf r2c4", capR[2][4], satMode ? 32767 : -1020);

    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
